mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing the single-port 1024×16 program/data memory between the `Core` CPU and a host port (I2C bootloader / PWM table loader). It drives the memory address, data and write-enable. Each cycle it grants at most one requester, alternating on ties. Read data comes back one cycle later, tagged with the originating port. An optional boot-hold mode keeps the core off the memory until the host finishes loading the program image.

## Interface
Parameters:
- `ADDR_W`, 10: memory address width (1024 words).
- `DATA_W`, 16: memory word width.
- `MAX_LOCK`, 8: maximum consecutive locked host grants while the core is waiting.

Ports:
- `clk`  in  1  system clock. One clock domain; all logic on the rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `core_req`  in  1  core access request.
- `core_we`  in  1  core write (1) / read (0).
- `core_addr`  in  ADDR_W  core address.
- `core_wdata`  in  DATA_W  core write data.
- `core_gnt`  out  1  core access accepted this cycle.
- `core_rvalid`  out  1  core read data valid.
- `core_rdata`  out  DATA_W  core read data.
- `host_req`, `host_we`, `host_addr`, `host_wdata`, `host_lock`  in  1/1/ADDR_W/DATA_W/1  host request fields; `host_lock` asks to keep ownership for a burst.
- `host_gnt`, `host_rvalid`  out  1  host accept / read valid.
- `host_rdata`  out  DATA_W  host read data.
- `host_boot_done`  in  1  host pulse that releases boot hold.
- `core_hold`  out  1  high while the core must stay idle (boot hold).
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_we`  out  1  memory write enable.
- `mem_rdata`  in  DATA_W  memory read data, registered, 1-cycle latency.

## Operation
- Grant logic is combinational from the current requests and registered arbitration state. At most one `*_gnt` is high per cycle.
- A requester holds `req` and all request fields stable until it sees `gnt`. It may re-request in the cycle after `gnt`, so back-to-back accesses run at 1 per cycle.
- `mem_addr`, `mem_wdata` and `mem_we` are muxed from the winner in the grant cycle. With no grant: `mem_we`=0, and `mem_addr`/`mem_wdata` hold their last value.
- Arbitration state:
  - `last` (CORE/HOST): the port granted most recently.
  - `lock_cnt` (0..MAX_LOCK): counts consecutive locked host grants.
- Decision each cycle:
  - Only one port requesting: that port wins.
  - Both requesting, host owns a lock (last=HOST, previous grant had `host_lock`=1) and `lock_cnt` < MAX_LOCK: host wins and `lock_cnt` increments.
  - Both requesting otherwise: the port ≠ `last` wins.
  - Once `lock_cnt` reaches MAX_LOCK, the core wins the next contested cycle. `lock_cnt` clears on any core grant and on any host grant with `host_lock`=0.
- Read response: a registered `rd_port` tag is set on a read grant. In the next cycle `mem_rdata` goes to the tagged port's `rdata` and that port's `rvalid` pulses for one cycle. Writes produce no `rvalid`.
- Non-tagged `rdata` holds its previous value.

## Timing
- Grant and memory command happen in cycle N. Read data and `rvalid` appear in cycle N+1. Read-after-write to the same address returns the new data.
- Reset values: `core_gnt`, `host_gnt`, `core_rvalid`, `host_rvalid`, `mem_we` = 0. `mem_addr`, `mem_wdata`, `core_rdata`, `host_rdata` = 0. `last` = HOST, so the core wins the first tie. `lock_cnt` = 0. `core_hold` per Configuration.
- Reset mid-operation: any pending `rvalid` is dropped and lock ownership is cleared.
- `req` deasserted in the grant cycle is a protocol violation. The bench must flag it; RTL behaviour is undefined.

## Configuration
- `MEM_ARB_BOOT_HOLD_EN` defined:
  - After `rst`, `core_hold`=1 and `core_req` is masked (no `core_gnt`), so the host has exclusive access.
  - A `host_boot_done` pulse clears `core_hold` on the next edge. It stays clear until the next `rst`.
- Undefined:
  - `core_hold` is tied to 0 and `host_boot_done` is ignored.
  - The core arbitrates from the first cycle after reset.

## Structure
- Shared package `mem_arb_pkg`:
  - `port_e` enum (PORT_CORE=0, PORT_HOST=1).
  - Default widths `MEM_ADDR_W`=10, `MEM_DATA_W`=16.
- One sub-module `mem_arb_pick`: pure 2-way decision (requests, `last`, lock state → winner). The top module holds the registers, memory mux and response routing.

## Test plan
- Reset, then `core_req` read at addr 5 alone, with mem[5]=0x4F20 → `core_gnt` in the same cycle; `core_rvalid`=1 with `core_rdata`=0x4F20 one cycle later.
- Core and host both reading every cycle for 6 cycles → grants alternate C,H,C,H,C,H; each `rvalid` is routed to the correct port.
- Host writes 0x1234 to addr 0x3FF, then core reads 0x3FF the next cycle → `core_rdata`=0x1234 (wrap to the top address).
- `host_lock`=1 burst of 20 with `core_req` constantly high → host gets 8 consecutive grants, core gets 1, then host resumes.
- `MEM_ARB_BOOT_HOLD_EN`: core requesting from reset → no `core_gnt` and `core_hold`=1 until a `host_boot_done` pulse; grant follows on the next contested/free cycle.
- Assert `rst` for one cycle while a read is outstanding → no `rvalid` next cycle; all outputs at reset values.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the program/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned MEM_ADDR_W = 10;
  localparam int unsigned MEM_DATA_W = 16;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_HOST = 1'b1
  } port_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the core, the host loader, the memory and the arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = mem_arb_pkg::MEM_ADDR_W,
  parameter int unsigned DATA_W = mem_arb_pkg::MEM_DATA_W
) ();

  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_lock;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              host_boot_done;
  logic              core_hold;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata,
    input  host_req, host_we, host_addr, host_wdata, host_lock,
    output host_gnt, host_rvalid, host_rdata,
    input  host_boot_done,
    output core_hold,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata
  );

  // Requesters and memory side.
  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata,
    output host_req, host_we, host_addr, host_wdata, host_lock,
    input  host_gnt, host_rvalid, host_rdata,
    output host_boot_done,
    input  core_hold,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Pure two-way grant decision: single requester wins, a live host lock keeps the host,
// otherwise the port that was not granted last wins the tie.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_LOCK = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             core_req_i,
  input  logic             host_req_i,
  input  port_e            last_i,
  input  logic             lock_own_i,
  input  logic [CNT_W-1:0] lock_cnt_i,
  output logic             core_win_o,
  output logic             host_win_o
);

  logic lock_live;

  assign lock_live = (last_i == PORT_HOST) && lock_own_i && (lock_cnt_i < CNT_W'(MAX_LOCK));

  always_comb begin
    core_win_o = 1'b0;
    host_win_o = 1'b0;
    if (core_req_i && host_req_i) begin
      if (lock_live)                  host_win_o = 1'b1;
      else if (last_i == PORT_HOST)   core_win_o = 1'b1;
      else                            host_win_o = 1'b1;
    end else begin
      core_win_o = core_req_i;
      host_win_o = host_req_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Core/host arbiter for the shared single-port program memory, with tagged read return.
// Optional boot hold (core kept off the memory until host_boot_done): MEM_ARB_BOOT_HOLD_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = MEM_ADDR_W,
  parameter int unsigned DATA_W   = MEM_DATA_W,
  parameter int unsigned MAX_LOCK = 8
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

  port_e             last_q, last_d;
  logic              lock_own_q, lock_own_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic              rd_valid_q, rd_valid_d;
  port_e             rd_port_q, rd_port_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              hold;
  logic              core_req_eff, host_req_eff;
  logic              core_win, host_win;
  logic              mem_we_c;
  logic              core_rvalid, host_rvalid;

`ifdef MEM_ARB_BOOT_HOLD_EN
  logic hold_q;

  always_ff @(posedge clk) begin
    if (rst)                     hold_q <= 1'b1;
    else if (bus.host_boot_done) hold_q <= 1'b0;
  end

  assign hold = hold_q;
`else
  logic unused_boot_done;

  assign hold             = 1'b0;
  assign unused_boot_done = bus.host_boot_done;
`endif

  // Nothing is granted while reset is applied.
  assign core_req_eff = bus.core_req & ~hold & ~rst;
  assign host_req_eff = bus.host_req & ~rst;

  mem_arb_pick #(
    .MAX_LOCK (MAX_LOCK),
    .CNT_W    (CNT_W)
  ) u_pick (
    .core_req_i (core_req_eff),
    .host_req_i (host_req_eff),
    .last_i     (last_q),
    .lock_own_i (lock_own_q),
    .lock_cnt_i (lock_cnt_q),
    .core_win_o (core_win),
    .host_win_o (host_win)
  );

  // Memory command mux and arbitration state update.
  always_comb begin
    last_d     = last_q;
    lock_own_d = lock_own_q;
    lock_cnt_d = lock_cnt_q;
    rd_valid_d = 1'b0;
    rd_port_d  = rd_port_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mem_we_c   = 1'b0;
    if (core_win) begin
      last_d     = PORT_CORE;
      lock_own_d = 1'b0;
      lock_cnt_d = '0;
      addr_d     = bus.core_addr;
      wdata_d    = bus.core_wdata;
      mem_we_c   = bus.core_we;
      rd_valid_d = ~bus.core_we;
      rd_port_d  = PORT_CORE;
    end else if (host_win) begin
      last_d     = PORT_HOST;
      lock_own_d = bus.host_lock;
      if (!bus.host_lock)                        lock_cnt_d = '0;
      else if (lock_cnt_q != CNT_W'(MAX_LOCK))   lock_cnt_d = lock_cnt_q + CNT_W'(1);
      addr_d     = bus.host_addr;
      wdata_d    = bus.host_wdata;
      mem_we_c   = bus.host_we;
      rd_valid_d = ~bus.host_we;
      rd_port_d  = PORT_HOST;
    end
  end

  // Read return: memory data is steered to the tagged port; the other port keeps its data.
  always_comb begin
    core_rvalid  = rd_valid_q & (rd_port_q == PORT_CORE) & ~rst;
    host_rvalid  = rd_valid_q & (rd_port_q == PORT_HOST) & ~rst;
    core_rdata_d = core_rvalid ? bus.mem_rdata : core_rdata_q;
    host_rdata_d = host_rvalid ? bus.mem_rdata : host_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q       <= PORT_HOST;
      lock_own_q   <= 1'b0;
      lock_cnt_q   <= '0;
      rd_valid_q   <= 1'b0;
      rd_port_q    <= PORT_CORE;
      addr_q       <= '0;
      wdata_q      <= '0;
      core_rdata_q <= '0;
      host_rdata_q <= '0;
    end else begin
      last_q       <= last_d;
      lock_own_q   <= lock_own_d;
      lock_cnt_q   <= lock_cnt_d;
      rd_valid_q   <= rd_valid_d;
      rd_port_q    <= rd_port_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      core_rdata_q <= core_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign bus.core_gnt    = core_win;
  assign bus.host_gnt    = host_win;
  assign bus.core_rvalid = core_rvalid;
  assign bus.host_rvalid = host_rvalid;
  assign bus.core_rdata  = core_rdata_d;
  assign bus.host_rdata  = host_rdata_d;
  assign bus.core_hold   = hold;
  assign bus.mem_addr    = addr_d;
  assign bus.mem_wdata   = wdata_d;
  assign bus.mem_we      = mem_we_c;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed tables and sequences plus random traffic against a reference model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 16;
  localparam int ML = 8;
`ifdef MEM_ARB_BOOT_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  typedef struct {
    logic          rst, cr, cw;
    logic [AW-1:0] ca;
    logic [DW-1:0] cd;
    logic          hr, hw;
    logic [AW-1:0] ha;
    logic [DW-1:0] hd;
    logic          hl, bd;
    logic          e_cg, e_hg, e_we, e_crv, e_hrv;
    logic [DW-1:0] e_rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  logic [DW-1:0] mem     [1024];
  logic [DW-1:0] ref_mem [1024];
  int checks = 0;
  int failures = 0;

  // Reference model state
  port_e         m_last, m_pp;
  bit            m_prev_lock, m_pv, m_hold, m_known;
  int            m_run;
  logic [DW-1:0] m_pd, m_wdata, m_crd, m_hrd;
  logic [AW-1:0] m_addr;
  // Protocol monitor state
  bit            p_c, p_h, p_cw, p_hw, p_hl;
  logic [AW-1:0] p_ca, p_ha;
  logic [DW-1:0] p_cd, p_hd;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(ML)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    return (i == 5) ? 16'h4F20 : 16'(i * 37 + 16'h1000);
  endfunction

  // Registered-read memory behind the arbiter
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
    end else begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  function automatic vec_t mk(input logic cr, cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                              input logic hr, hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                              input logic hl, ecg, ehg, ewe, ecrv, ehrv, input logic [DW-1:0] erd);
    vec_t v;
    v.rst = 1'b0; v.bd = 1'b0;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.hr = hr; v.hw = hw; v.ha = ha; v.hd = hd; v.hl = hl;
    v.e_cg = ecg; v.e_hg = ehg; v.e_we = ewe; v.e_crv = ecrv; v.e_hrv = ehrv; v.e_rd = erd;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(0, 0, '0, '0, 0, 0, '0, '0, 0, 0, 0, 0, 0, 0, '0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock cycle: drive, check at the falling edge, then advance the model across the edge.
  task automatic cyc(input vec_t v, input bit tchk, input bit rvchk, output bit ogc, output bit ogh);
    bit creq, hreq, gc, gh, crv, hrv, ewe;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewd, ecrd, ehrd;
    rst = v.rst;
    bus.core_req = v.cr; bus.core_we = v.cw; bus.core_addr = v.ca; bus.core_wdata = v.cd;
    bus.host_req = v.hr; bus.host_we = v.hw; bus.host_addr = v.ha; bus.host_wdata = v.hd;
    bus.host_lock = v.hl; bus.host_boot_done = v.bd;
    @(negedge clk);
    creq = v.cr && !m_hold && !v.rst;
    hreq = v.hr && !v.rst;
    gc = 1'b0; gh = 1'b0;
    if (creq && hreq) begin
      if (m_last == PORT_HOST && m_prev_lock && m_run < ML) gh = 1'b1;
      else if (m_last == PORT_HOST) gc = 1'b1;
      else gh = 1'b1;
    end else begin
      gc = creq; gh = hreq;
    end
    eaddr = gc ? v.ca : (gh ? v.ha : m_addr);
    ewd   = gc ? v.cd : (gh ? v.hd : m_wdata);
    ewe   = gc ? v.cw : (gh ? v.hw : 1'b0);
    crv   = m_pv && (m_pp == PORT_CORE) && !v.rst;
    hrv   = m_pv && (m_pp == PORT_HOST) && !v.rst;
    ecrd  = crv ? m_pd : m_crd;
    ehrd  = hrv ? m_pd : m_hrd;

    chk("core_gnt", 32'(bus.core_gnt), 32'(gc));
    chk("host_gnt", 32'(bus.host_gnt), 32'(gh));
    chk("one_hot_gnt", 32'(bus.core_gnt & bus.host_gnt), 32'(0));
    chk("mem_we", 32'(bus.mem_we), 32'(ewe));
    chk("core_rvalid", 32'(bus.core_rvalid), 32'(crv));
    chk("host_rvalid", 32'(bus.host_rvalid), 32'(hrv));
    if (m_known) begin
      chk("mem_addr", 32'(bus.mem_addr), 32'(eaddr));
      chk("mem_wdata", 32'(bus.mem_wdata), 32'(ewd));
      chk("core_rdata", 32'(bus.core_rdata), 32'(ecrd));
      chk("host_rdata", 32'(bus.host_rdata), 32'(ehrd));
      chk("core_hold", 32'(bus.core_hold), 32'(m_hold));
    end
    if (tchk) begin
      chk("tbl_core_gnt", 32'(bus.core_gnt), 32'(v.e_cg));
      chk("tbl_host_gnt", 32'(bus.host_gnt), 32'(v.e_hg));
      chk("tbl_mem_we", 32'(bus.mem_we), 32'(v.e_we));
      chk("tbl_core_rvalid", 32'(bus.core_rvalid), 32'(v.e_crv));
      chk("tbl_host_rvalid", 32'(bus.host_rvalid), 32'(v.e_hrv));
      if (v.e_crv) chk("tbl_core_rdata", 32'(bus.core_rdata), 32'(v.e_rd));
      if (v.e_hrv) chk("tbl_host_rdata", 32'(bus.host_rdata), 32'(v.e_rd));
    end
    if (rvchk) begin
      chk("rst_core_gnt", 32'(bus.core_gnt), 32'(0));
      chk("rst_host_gnt", 32'(bus.host_gnt), 32'(0));
      chk("rst_core_rvalid", 32'(bus.core_rvalid), 32'(0));
      chk("rst_host_rvalid", 32'(bus.host_rvalid), 32'(0));
      chk("rst_mem_we", 32'(bus.mem_we), 32'(0));
      chk("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
      chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'(0));
      chk("rst_core_rdata", 32'(bus.core_rdata), 32'(0));
      chk("rst_host_rdata", 32'(bus.host_rdata), 32'(0));
      chk("rst_core_hold", 32'(bus.core_hold), 32'(HOLD));
    end
    // A request that was not granted must stay asserted with unchanged fields.
    if (!v.rst && p_c && (!v.cr || v.cw != p_cw || v.ca != p_ca || v.cd != p_cd)) begin
      failures++;
      $display("FAIL protocol_core at %0t: req=%0b dropped or changed before grant", $time, v.cr);
    end
    if (!v.rst && p_h && (!v.hr || v.hw != p_hw || v.ha != p_ha || v.hd != p_hd || v.hl != p_hl)) begin
      failures++;
      $display("FAIL protocol_host at %0t: req=%0b dropped or changed before grant", $time, v.hr);
    end
    p_c = v.cr && !bus.core_gnt && !v.rst; p_cw = v.cw; p_ca = v.ca; p_cd = v.cd;
    p_h = v.hr && !bus.host_gnt && !v.rst; p_hw = v.hw; p_ha = v.ha; p_hd = v.hd; p_hl = v.hl;
    ogc = bus.core_gnt;
    ogh = bus.host_gnt;

    if (v.rst) begin
      m_last = PORT_HOST; m_prev_lock = 0; m_run = 0; m_pv = 0;
      m_addr = '0; m_wdata = '0; m_crd = '0; m_hrd = '0;
      m_hold = HOLD; m_known = 1;
    end else begin
      m_crd = ecrd; m_hrd = ehrd; m_pv = 0;
      if (gc || gh) begin
        m_addr = eaddr; m_wdata = ewd;
        if (ewe) ref_mem[eaddr] = ewd;
        else begin m_pv = 1; m_pp = gc ? PORT_CORE : PORT_HOST; m_pd = ref_mem[eaddr]; end
        if (gc) begin
          m_last = PORT_CORE; m_prev_lock = 0; m_run = 0;
        end else begin
          m_last = PORT_HOST; m_prev_lock = v.hl;
          m_run = v.hl ? ((m_run + 1 > ML) ? ML : m_run + 1) : 0;
        end
      end
      if (HOLD && v.bd) m_hold = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    vec_t tbl [13];
    bit gc, gh, cp, hp, c_we, h_we, h_lock, prev_core, resume_ok;
    logic [AW-1:0] c_addr, h_addr;
    logic [DW-1:0] c_wd, h_wd;
    int hcnt, ccnt, first_run;

    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    m_last = PORT_HOST; m_pp = PORT_CORE; m_prev_lock = 0; m_pv = 0; m_hold = 0; m_known = 0;
    m_run = 0; m_pd = '0; m_wdata = '0; m_crd = '0; m_hrd = '0; m_addr = '0;
    p_c = 0; p_h = 0;
    mem_init = 1'b1;
    v = idle(); v.rst = 1'b1;
    cyc(v, 0, 0, gc, gh);
    cyc(v, 0, 0, gc, gh);
    mem_init = 1'b0;
    cyc(idle(), 0, 1, gc, gh);

`ifdef MEM_ARB_BOOT_HOLD_EN
    for (int i = 0; i < 3; i++) begin
      cyc(mk(1, 0, 10'd9, '0, 0, 0, '0, '0, 0, 0, 0, 0, 0, 0, '0), 1, 0, gc, gh);
    end
    v = mk(1, 0, 10'd9, '0, 0, 0, '0, '0, 0, 0, 0, 0, 0, 0, '0); v.bd = 1'b1;
    cyc(v, 1, 0, gc, gh);
    cyc(mk(1, 0, 10'd9, '0, 0, 0, '0, '0, 0, 1, 0, 0, 0, 0, '0), 1, 0, gc, gh);
    cyc(mk(0, 0, '0, '0, 0, 0, '0, '0, 0, 0, 0, 0, 1, 0, init_val(9)), 1, 0, gc, gh);
`endif

    // Single reads, alternation on ties, write then read of the top address
    tbl[0]  = mk(1, 0, 10'd5,  '0, 0, 0, '0,     '0, 0, 1, 0, 0, 0, 0, '0);
    tbl[1]  = mk(0, 0, '0,     '0, 1, 0, 10'd6,  '0, 0, 0, 1, 0, 1, 0, 16'h4F20);
    tbl[2]  = mk(1, 0, 10'd10, '0, 1, 0, 10'd20, '0, 0, 1, 0, 0, 0, 1, init_val(6));
    tbl[3]  = mk(1, 0, 10'd11, '0, 1, 0, 10'd20, '0, 0, 0, 1, 0, 1, 0, init_val(10));
    tbl[4]  = mk(1, 0, 10'd11, '0, 1, 0, 10'd21, '0, 0, 1, 0, 0, 0, 1, init_val(20));
    tbl[5]  = mk(1, 0, 10'd12, '0, 1, 0, 10'd21, '0, 0, 0, 1, 0, 1, 0, init_val(11));
    tbl[6]  = mk(1, 0, 10'd12, '0, 1, 0, 10'd22, '0, 0, 1, 0, 0, 0, 1, init_val(21));
    tbl[7]  = mk(1, 0, 10'd13, '0, 1, 0, 10'd22, '0, 0, 0, 1, 0, 1, 0, init_val(12));
    tbl[8]  = mk(1, 0, 10'd13, '0, 0, 0, '0,     '0, 0, 1, 0, 0, 0, 1, init_val(22));
    tbl[9]  = mk(0, 0, '0,     '0, 0, 0, '0,     '0, 0, 0, 0, 0, 1, 0, init_val(13));
    tbl[10] = mk(0, 0, '0,     '0, 1, 1, 10'h3FF, 16'h1234, 0, 0, 1, 1, 0, 0, '0);
    tbl[11] = mk(1, 0, 10'h3FF, '0, 0, 0, '0,    '0, 0, 1, 0, 0, 0, 0, '0);
    tbl[12] = mk(0, 0, '0,     '0, 0, 0, '0,     '0, 0, 0, 0, 0, 1, 0, 16'h1234);
    for (int i = 0; i < 13; i++) cyc(tbl[i], 1, 0, gc, gh);

    // Locked host burst of 20 writes against a constantly requesting core
    hcnt = 0; ccnt = 0; first_run = -1; prev_core = 0; resume_ok = 0;
    for (int n = 0; n < 80 && hcnt < 20; n++) begin
      v = mk(1, 0, 10'h050, '0, 1, 1, 10'(32'h100 + hcnt), 16'(32'hA000 + hcnt), 1, 0, 0, 0, 0, 0, '0);
      cyc(v, 0, 0, gc, gh);
      if (gh && prev_core && ccnt == 1) resume_ok = 1;
      prev_core = gc;
      if (gh) hcnt++;
      if (gc) begin
        if (ccnt == 0) first_run = hcnt;
        ccnt++;
      end
    end
    chk("burst_done", 32'(hcnt), 32'd20);
    chk("burst_first_run", 32'(first_run), 32'd8);
    chk("burst_core_grants", 32'(ccnt), 32'd2);
    chk("burst_host_resume", 32'(resume_ok), 32'd1);
    cyc(mk(1, 0, 10'h050, '0, 0, 0, '0, '0, 0, 0, 0, 0, 0, 0, '0), 0, 0, gc, gh);
    chk("burst_core_drain", 32'(gc), 32'd1);

    // Reset while a locked host read is outstanding
    cyc(mk(0, 0, '0, '0, 1, 0, 10'd7, '0, 1, 0, 0, 0, 0, 0, '0), 0, 0, gc, gh);
    chk("pre_rst_host_gnt", 32'(gh), 32'd1);
    v = idle(); v.rst = 1'b1;
    cyc(v, 1, 0, gc, gh);
    v = idle(); v.bd = HOLD;
    cyc(v, 0, 1, gc, gh);
    cyc(mk(1, 0, 10'd3, '0, 1, 0, 10'd4, '0, 0, 1, 0, 0, 0, 0, '0), 1, 0, gc, gh);
    cyc(mk(0, 0, '0, '0, 1, 0, 10'd4, '0, 0, 0, 1, 0, 1, 0, init_val(3)), 1, 0, gc, gh);

    // Random traffic against the model
    cp = 0; hp = 0;
    c_we = 0; h_we = 0; h_lock = 0; c_addr = '0; h_addr = '0; c_wd = '0; h_wd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!cp && $urandom_range(0, 3) != 0) begin
        cp = 1; c_we = 1'($urandom_range(0, 1));
        c_addr = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 7)) : 10'($urandom);
        c_wd = 16'($urandom);
      end
      if (!hp && $urandom_range(0, 3) != 0) begin
        hp = 1; h_we = 1'($urandom_range(0, 1));
        h_addr = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 7)) : 10'($urandom);
        h_wd = 16'($urandom); h_lock = ($urandom_range(0, 2) == 0);
      end
      v = mk(cp, c_we, c_addr, c_wd, hp, h_we, h_addr, h_wd, h_lock, 0, 0, 0, 0, 0, '0);
      v.bd = ($urandom_range(0, 15) == 0);
      cyc(v, 0, 0, gc, gh);
      if (gc) cp = 0;
      if (gh) hp = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
